// File: rtl/full_adder_structural.sv
// 1-bit full adder built from gate-level assigns.
// Ports:
//   a, b  - addend bits
//   cin   - carry in
//   s     - sum bit (a ^ b ^ cin)
//   cout  - carry out (majority of a, b, cin)
module full_adder_structural (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic ab_x;
  logic ab_a;
  logic cx_a;

  assign ab_x = a ^ b;
  assign ab_a = a & b;
  assign cx_a = ab_x & cin;
  assign s    = ab_x ^ cin;
  assign cout = ab_a | cx_a;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder stepped over WIDTH bits, LSB first, one bit per clock.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - request; accepted when not busy (IDLE or DONE)
//   a, b       - operands, sampled on the accepting edge only
//   carry_in   - initial carry, sampled on the accepting edge only
//   busy       - high while the addition is in progress
//   done       - one-cycle pulse; sum/carry_out valid from this cycle
//   sum        - registered result, held until the next completion
//   carry_out  - registered final carry, held with sum
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr;
  logic [WIDTH-1:0] s_next;
  logic             c_q;
  logic [CntW-1:0]  cnt;
  logic             fa_s, fa_c;
  logic             accept;
  logic             last;

  full_adder_structural u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (c_q),
    .s   (fa_s),
    .cout(fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB result.
  generate
    if (WIDTH == 1) begin : g_w1
      assign s_next = fa_s;
    end else begin : g_wn
      assign s_next = {fa_s, s_sr[WIDTH-1:1]};
    end
  endgenerate

  assign last = (cnt == CntW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        accept = start;
        if (start) state_d = StRun;
      end
      StRun: begin
        busy = 1'b1;
        if (last) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        accept  = start;
        state_d = start ? StRun : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      s_sr      <= '0;
      c_q       <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      c_q  <= carry_in;
      cnt  <= '0;
    end else if (state_q == StRun) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      s_sr <= s_next;
      c_q  <= fa_c;
      cnt  <= cnt + CntW'(1);
      if (last) begin
        sum       <= s_next;
        carry_out <= fa_c;
      end
    end
  end

endmodule
